// File: rtl/rsa_encryptor.sv
// Sequential modular exponentiation engine: output_data = m^e mod n.
// Each exponent step is one multiply cycle followed by a 26-cycle
// restoring shift-subtract reduction of the 26-bit product by n.
module rsa_encryptor (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] data,
    input  logic [2:0]  input_data_type,
    output logic [15:0] output_data,
    output logic        done
);

    localparam logic [2:0]  CmdEncrypt = 3'd1;
    localparam logic [2:0]  CmdLoadN   = 3'd2;
    localparam logic [2:0]  CmdLoadE   = 3'd3;
    localparam logic [12:0] ResetE     = 13'd17;
    localparam logic [12:0] ResetN     = 13'd3233;
    localparam logic [4:0]  LastBit    = 5'd25;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StMult,
        StMod,
        StDone
    } state_t;

    state_t      state;
    logic [12:0] e;
    logic [12:0] n;
    logic [12:0] m;
    logic [12:0] result;
    logic [25:0] product;
    logic [12:0] counter;
    logic [4:0]  bit_cnt;

    // result doubles as the partial remainder while in MOD.
    logic [13:0] trial;
    logic [13:0] diff;
    logic [12:0] rem_next;

    // One restoring-division step: bring in the next product bit, subtract n if it fits.
    always_comb begin
        trial = {result, product[25]};
        diff  = trial - {1'b0, n};
        if (n == 13'd0) begin
            rem_next = '0;
        end else if (trial >= {1'b0, n}) begin
            rem_next = diff[12:0];
        end else begin
            rem_next = trial[12:0];
        end
    end

    // Controller and datapath registers, outputs registered on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            e           <= ResetE;
            n           <= ResetN;
            m           <= '0;
            result      <= '0;
            product     <= '0;
            counter     <= '0;
            bit_cnt     <= '0;
            output_data <= '0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (input_data_type == CmdEncrypt) begin
                        m     <= data;
                        done  <= 1'b0;
                        state <= StInit;
                    end else if (input_data_type == CmdLoadN) begin
                        n <= data;
                    end else if (input_data_type == CmdLoadE) begin
                        e <= data;
                    end
                end
                StInit: begin
                    result  <= 13'd1;
                    counter <= e;
                    if (e == 13'd0) begin
                        // 1 mod n, with n = 1 giving zero.
                        output_data <= (n == 13'd1) ? 16'd0 : 16'd1;
                        done        <= 1'b1;
                        state       <= StDone;
                    end else begin
                        state <= StMult;
                    end
                end
                StMult: begin
                    product <= {13'd0, result} * {13'd0, m};
                    counter <= counter - 13'd1;
                    result  <= '0;
                    bit_cnt <= '0;
                    state   <= StMod;
                end
                StMod: begin
                    result  <= rem_next;
                    product <= {product[24:0], 1'b0};
                    if (bit_cnt == LastBit) begin
                        if (counter != 13'd0) begin
                            state <= StMult;
                        end else begin
                            output_data <= {3'b000, rem_next};
                            done        <= 1'b1;
                            state       <= StDone;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_encryptor.sv
// Directed bench for rsa_encryptor: defaults, reprogramming, latency,
// busy-command rejection, e = 0 / n = 1 corners and mid-run reset.
module tb_rsa_encryptor;

    logic        clk;
    logic        reset;
    logic [12:0] data;
    logic [2:0]  input_data_type;
    logic [15:0] output_data;
    logic        done;

    int checks = 0;
    int errors = 0;

    rsa_encryptor dut (
        .clk             (clk),
        .reset           (reset),
        .data            (data),
        .input_data_type (input_data_type),
        .output_data     (output_data),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference m^e mod n by repeated multiplication.
    function automatic int modexp(input int mm, input int ee, input int nn);
        longint r;
        if (ee == 0) return (nn == 1) ? 0 : 1;
        if (nn == 0) return 0;
        r = 1;
        for (int i = 0; i < ee; i++) r = (r * mm) % nn;
        return int'(r);
    endfunction

    // One-cycle command pulse; its rising edge is edge 0.
    task automatic command(input logic [2:0] code, input logic [12:0] d);
        @(negedge clk);
        input_data_type = code;
        data            = d;
        @(negedge clk);
        input_data_type = 3'd0;
    endtask

    // Counts edges after edge 0 until done is seen high, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic encrypt(input string tag, input int mm, input int exp_val, input int exp_cyc);
        int cyc;
        command(3'd1, 13'(mm));
        check({tag, "_busy"}, 32'(done), 32'd0);
        wait_done(cyc);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_data"}, 32'(output_data), 32'(exp_val));
        if (exp_cyc >= 0) check({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        int cyc;
        logic [15:0] held;

        reset           = 1'b1;
        data            = '0;
        input_data_type = '0;
        repeat (2) @(negedge clk);
        check("reset_out", 32'(output_data), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Defaults e = 17, n = 3233 with hand-computed values.
        encrypt("def_m2", 2, 1752, 460);
        encrypt("def_m0", 0, 0, 460);
        encrypt("def_m1", 1, 1, 460);
        encrypt("def_m65", 65, 2790, 460);
        encrypt("def_m5", 5, 3086, 460);
        // Message larger than n is not pre-reduced.
        encrypt("def_big", 8000, modexp(8000, 17, 3233), 460);

        // Stability after done.
        held = output_data;
        repeat (20) @(negedge clk);
        check("stable_out", 32'(output_data), 32'(held));
        check("stable_done", 32'(done), 32'd1);

        for (int m = 3; m < 24; m++) encrypt("def_sweep", m, modexp(m, 17, 3233), -1);

        // Loads in DONE keep done/output; then reprogram n = 323.
        held = output_data;
        command(3'd3, 13'd17);
        command(3'd2, 13'd323);
        check("load_keep_done", 32'(done), 32'd1);
        check("load_keep_out", 32'(output_data), 32'(held));
        encrypt("n323_m2", 2, 257, 460);
        for (int m = 0; m < 24; m++) encrypt("n323_sweep", m, modexp(m, 17, 323), -1);

        // No-op codes change nothing.
        held = output_data;
        command(3'd5, 13'd1);
        command(3'd0, 13'd2);
        check("noop_out", 32'(output_data), 32'(held));
        check("noop_done", 32'(done), 32'd1);

        // Back to n = 3233; commands during the run are ignored.
        command(3'd2, 13'd3233);
        command(3'd1, 13'd5);
        repeat (40) @(negedge clk);
        input_data_type = 3'd2; data = 13'd7;
        @(negedge clk);
        input_data_type = 3'd0;
        repeat (100) @(negedge clk);
        input_data_type = 3'd1; data = 13'd9;
        @(negedge clk);
        input_data_type = 3'd0;
        check("busy_still_low", 32'(done), 32'd0);
        wait_done(cyc);
        check("busy_data", 32'(output_data), 32'd3086);
        encrypt("busy_n_kept", 2, 1752, 460);

        // e = 0 and n = 1 corners.
        command(3'd3, 13'd0);
        encrypt("e0_m100", 100, 1, 1);
        command(3'd2, 13'd1);
        encrypt("e0_n1", 100, 0, 1);
        command(3'd3, 13'd3);
        encrypt("e3_n1", 100, 0, 82);
        // n = 0 forces zero.
        command(3'd2, 13'd0);
        encrypt("n0", 7, 0, 82);

        // Reset during MOD restores defaults.
        command(3'd1, 13'd2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_out", 32'(output_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        encrypt("rst_defaults", 2, 1752, 460);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
